// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: sequences power-down, reset and lock qualification
// whenever new divider/phase settings are accepted, and recovers automatically from lock loss.
module pll_reconfig_ctrl #(
   parameter int PWD_CYCLES   = 10,
   parameter int RST_CYCLES   = 10,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int LOCK_STABLE  = 16,
   parameter int MAX_RETRY    = 2,
   parameter int INIT_IDIV    = 2,
   parameter int INIT_FDIV    = 32,
   parameter int INIT_ODIV0   = 100,
   parameter int INIT_DUTY0   = 100,
   parameter int INIT_PHASE0  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [9:0]  cfg_idiv,
   input  logic [9:0]  cfg_fdiv,
   input  logic [9:0]  cfg_odiv0,
   input  logic [9:0]  cfg_duty0,
   input  logic [12:0] cfg_phase0,
   input  logic        pll_lock,
   output logic        pll_pwd,
   output logic        pll_rst,
   output logic        rstodiv,
   output logic [9:0]  dyn_idiv,
   output logic [9:0]  dyn_fdiv,
   output logic [9:0]  dyn_odiv0,
   output logic [9:0]  dyn_duty0,
   output logic [12:0] dyn_phase0,
   output logic        clkout0_gate,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        lock_lost,
   output logic [1:0]  retry_cnt
);

   typedef enum logic [2:0] {BOOT, IDLE, PWD, RST, WAIT_LOCK, STABLE, FAIL} state_t;

   // One shared phase counter serves PWD, RST and STABLE, so it is sized for the longest.
   localparam int PC_MAX0 = (PWD_CYCLES > RST_CYCLES) ? PWD_CYCLES : RST_CYCLES;
   localparam int PC_MAX  = (PC_MAX0 > LOCK_STABLE) ? PC_MAX0 : LOCK_STABLE;
   localparam int PC_W    = $clog2(PC_MAX + 1);
   localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);

   state_t          state, state_n;
   logic [PC_W-1:0] cnt, cnt_n;
   logic [TO_W-1:0] to_cnt, to_n;
   logic [1:0]      retry_n;
   logic            gate_n, done_n, lost_n, load;
   logic            sync1, lock_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         cnt          <= '0;
         to_cnt       <= '0;
         retry_cnt    <= '0;
         clkout0_gate <= 1'b1;
         done         <= 1'b0;
         lock_lost    <= 1'b0;
         sync1        <= 1'b0;
         lock_s       <= 1'b0;
         dyn_idiv     <= 10'(INIT_IDIV);
         dyn_fdiv     <= 10'(INIT_FDIV);
         dyn_odiv0    <= 10'(INIT_ODIV0);
         dyn_duty0    <= 10'(INIT_DUTY0);
         dyn_phase0   <= 13'(INIT_PHASE0);
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         to_cnt       <= to_n;
         retry_cnt    <= retry_n;
         clkout0_gate <= gate_n;
         done         <= done_n;
         lock_lost    <= lost_n;
         sync1        <= pll_lock;
         lock_s       <= sync1;
         if (load) begin
            dyn_idiv   <= cfg_idiv;
            dyn_fdiv   <= cfg_fdiv;
            dyn_odiv0  <= cfg_odiv0;
            dyn_duty0  <= cfg_duty0;
            dyn_phase0 <= cfg_phase0;
         end
      end
   end

   // In IDLE a request is evaluated after lock loss so that it overrides the recovery
   // sequence while the lock_lost pulse is still reported.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      to_n    = to_cnt;
      retry_n = retry_cnt;
      gate_n  = clkout0_gate;
      done_n  = 1'b0;
      lost_n  = 1'b0;
      load    = 1'b0;
      case (state)
         BOOT, RST: begin
            if (cnt == PC_W'(RST_CYCLES - 1)) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
               to_n    = '0;
            end else begin
               cnt_n = cnt + PC_W'(1);
            end
         end
         IDLE: begin
            if (!clkout0_gate && !lock_s) begin
               lost_n  = 1'b1;
               gate_n  = 1'b1;
               state_n = RST;
               cnt_n   = '0;
               retry_n = '0;
            end
            if (cfg_valid) begin
               load    = 1'b1;
               gate_n  = 1'b1;
               state_n = PWD;
               cnt_n   = '0;
               retry_n = '0;
            end
         end
         PWD: begin
            if (cnt == PC_W'(PWD_CYCLES - 1)) begin
               state_n = RST;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + PC_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_n = STABLE;
               cnt_n   = '0;
            end else if (to_cnt == TO_W'(LOCK_TIMEOUT - 1)) begin
               if (int'(retry_cnt) < MAX_RETRY) begin
                  state_n = RST;
                  cnt_n   = '0;
                  retry_n = retry_cnt + 2'd1;
               end else begin
                  state_n = FAIL;
               end
            end else begin
               to_n = to_cnt + TO_W'(1);
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_n = WAIT_LOCK;
            end else if (cnt == PC_W'(LOCK_STABLE - 1)) begin
               state_n = IDLE;
               gate_n  = 1'b0;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + PC_W'(1);
            end
         end
         FAIL:    state_n = IDLE;
         default: state_n = BOOT;
      endcase
   end

   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign pll_pwd   = (state == PWD);
   assign pll_rst   = (state == RST) || (state == BOOT);
   assign rstodiv   = pll_rst;
   assign err       = (state == FAIL);

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: boot, reconfiguration, lock glitch, lock loss,
// retry timeout and mid-sequence reset, with a shortened lock timeout.
module tb_pll_reconfig_ctrl;

   localparam int TO = 300;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [9:0]  cfg_idiv = '0, cfg_fdiv = '0, cfg_odiv0 = '0, cfg_duty0 = '0;
   logic [12:0] cfg_phase0 = '0;
   logic        pll_lock = 1'b0;
   logic        pll_pwd, pll_rst, rstodiv;
   logic [9:0]  dyn_idiv, dyn_fdiv, dyn_odiv0, dyn_duty0;
   logic [12:0] dyn_phase0;
   logic        clkout0_gate, busy, done, err, lock_lost;
   logic [1:0]  retry_cnt;

   int checks = 0;
   int failures = 0;
   int n;

   pll_reconfig_ctrl #(.LOCK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_idiv(cfg_idiv), .cfg_fdiv(cfg_fdiv), .cfg_odiv0(cfg_odiv0),
      .cfg_duty0(cfg_duty0), .cfg_phase0(cfg_phase0), .pll_lock(pll_lock),
      .pll_pwd(pll_pwd), .pll_rst(pll_rst), .rstodiv(rstodiv),
      .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv), .dyn_odiv0(dyn_odiv0),
      .dyn_duty0(dyn_duty0), .dyn_phase0(dyn_phase0), .clkout0_gate(clkout0_gate),
      .busy(busy), .done(done), .err(err), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [9:0] idiv, input logic [9:0] fdiv,
                                 input logic [9:0] odiv, input logic [9:0] duty,
                                 input logic [12:0] phase);
      cfg_idiv   = idiv;
      cfg_fdiv   = fdiv;
      cfg_odiv0  = odiv;
      cfg_duty0  = duty;
      cfg_phase0 = phase;
      cfg_valid  = 1'b1;
   endtask

   task automatic count_done(input string tag, input int exp);
      n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_output(tag, n, exp);
   endtask

   task automatic wait_while_rst_or_pwd();
      n = 0;
      while ((pll_pwd || pll_rst) && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_output("rst_pll_rst", pll_rst, 1);
      check_output("rst_rstodiv", rstodiv, 1);
      check_output("rst_pll_pwd", pll_pwd, 0);
      check_output("rst_gate", clkout0_gate, 1);
      check_output("rst_busy", busy, 1);
      check_output("rst_ready", cfg_ready, 0);
      check_output("rst_pulses", {done, err, lock_lost}, 0);
      check_output("rst_retry", retry_cnt, 0);
      check_output("rst_idiv", dyn_idiv, 2);
      check_output("rst_phase0", dyn_phase0, 16);

      // Boot: reset pulse length, then lock 200 cycles after release
      rst = 1'b0;
      n = 0;
      while (pll_rst && n < 100) begin
         n++;
         @(negedge clk);
      end
      check_output("boot_rst_len", n, 10);
      repeat (190) @(negedge clk);
      pll_lock = 1'b1;
      count_done("boot_done_latency", 19);
      check_output("boot_gate", clkout0_gate, 0);
      check_output("boot_idiv", dyn_idiv, 2);
      check_output("boot_fdiv", dyn_fdiv, 32);
      check_output("boot_odiv0", dyn_odiv0, 100);
      check_output("boot_ready", cfg_ready, 1);
      check_output("boot_busy", busy, 0);
      @(negedge clk);
      check_output("boot_done_pulse", done, 0);

      // Reconfiguration with a request issued during PWD that must be ignored
      apply_stimulus(10'd3, 10'd40, 10'd200, 10'd200, 13'd5);
      @(negedge clk);
      check_output("cfg_odiv0", dyn_odiv0, 200);
      check_output("cfg_duty0", dyn_duty0, 200);
      check_output("cfg_idiv", dyn_idiv, 3);
      check_output("cfg_gate", clkout0_gate, 1);
      check_output("cfg_ready_busy", {cfg_ready, busy}, 2'b01);
      apply_stimulus(10'd9, 10'd9, 10'd7, 10'd7, 13'd7);
      n = 0;
      while (pll_pwd && n < 100) begin
         n++;
         @(negedge clk);
         cfg_valid = 1'b0;
      end
      check_output("cfg_pwd_len", n, 10);
      check_output("cfg_rstodiv", rstodiv, 1);
      n = 0;
      while (pll_rst && n < 100) begin
         n++;
         @(negedge clk);
      end
      check_output("cfg_rst_len", n, 10);
      count_done("cfg_done_latency", 17);
      check_output("cfg_ignored_odiv0", dyn_odiv0, 200);
      check_output("cfg_phase0", dyn_phase0, 5);
      check_output("cfg_gate_open", clkout0_gate, 0);

      // Lock glitch of 3 cycles inside STABLE
      apply_stimulus(10'd3, 10'd40, 10'd150, 10'd200, 13'd5);
      @(negedge clk);
      cfg_valid = 1'b0;
      wait_while_rst_or_pwd();
      repeat (4) @(negedge clk);
      pll_lock = 1'b0;
      repeat (3) @(negedge clk);
      pll_lock = 1'b1;
      check_output("glitch_busy_nodone", {busy, done}, 2'b10);
      count_done("glitch_done_latency", 19);
      check_output("glitch_odiv0", dyn_odiv0, 150);

      // Lock loss in IDLE triggers automatic recovery
      pll_lock = 1'b0;
      n = 0;
      while (!lock_lost && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_output("loss_latency", n, 3);
      check_output("loss_gate", clkout0_gate, 1);
      check_output("loss_rst_pwd", {pll_rst, pll_pwd}, 2'b10);
      check_output("loss_retry", retry_cnt, 0);
      @(negedge clk);
      check_output("loss_pulse", lock_lost, 0);
      wait_while_rst_or_pwd();
      pll_lock = 1'b1;
      count_done("loss_done_latency", 19);
      check_output("loss_gate_open", clkout0_gate, 0);

      // Lock loss coinciding with a request, then lock never returns
      pll_lock = 1'b0;
      repeat (2) @(negedge clk);
      apply_stimulus(10'd4, 10'd50, 10'd300, 10'd150, 13'd100);
      @(negedge clk);
      cfg_valid = 1'b0;
      check_output("both_lost", lock_lost, 1);
      check_output("both_pwd", pll_pwd, 1);
      check_output("both_odiv0", dyn_odiv0, 300);
      n = 0;
      while (!err && n < 3000) begin
         @(negedge clk);
         n++;
         if (done) failures++;
      end
      check_output("timeout_latency", n, 940);
      check_output("timeout_retry", retry_cnt, 2);
      check_output("timeout_gate", clkout0_gate, 1);
      check_output("timeout_no_done", done, 0);
      @(negedge clk);
      check_output("timeout_err_pulse", err, 0);
      check_output("timeout_idle", {busy, cfg_ready}, 2'b01);
      check_output("timeout_gate_after", clkout0_gate, 1);
      check_output("timeout_dyn_kept", dyn_odiv0, 300);

      // Reset asserted during WAIT_LOCK
      apply_stimulus(10'd5, 10'd60, 10'd55, 10'd55, 13'd55);
      @(negedge clk);
      cfg_valid = 1'b0;
      wait_while_rst_or_pwd();
      repeat (5) @(negedge clk);
      check_output("mid_waiting", {busy, pll_rst}, 2'b10);
      rst = 1'b1;
      @(negedge clk);
      check_output("mid_idiv", dyn_idiv, 2);
      check_output("mid_odiv0", dyn_odiv0, 100);
      check_output("mid_phase0", dyn_phase0, 16);
      check_output("mid_busy_ready", {busy, cfg_ready}, 2'b10);
      check_output("mid_outs", {pll_pwd, pll_rst, rstodiv, clkout0_gate}, 4'b0111);
      check_output("mid_pulses", {done, err, lock_lost}, 0);
      check_output("mid_retry", retry_cnt, 0);
      repeat (3) @(negedge clk);
      check_output("mid_hold_pulses", {done, err}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
